// File: rtl/opcode_decode_pipe.sv
// ---------------------------------------------------------------------------
// opcode_decode_pipe
//
// Purpose
//   Classifies the major opcode (instr[6:0]) of each incoming instruction into
//   a one-hot class vector, flags illegal encodings, and carries the decoded
//   entry through STAGES elastic pipeline registers between fetch and the
//   register-read stage. Optional classes: AMO (EN_AMO) and the RV64 word
//   opcodes OP-IMM-32 / OP-32 (EN_RV64). A saturating counter records every
//   illegal entry handed downstream.
//
// Parameters
//   STAGES   pipeline register count (1..4); latency in cycles with out_ready=1
//   EN_AMO   1: opcode 0101111 is legal, class bit 11
//   EN_RV64  1: opcodes 0011011 (class 12) and 0111011 (class 13) are legal
//   TAG_W    width of the sideband tag carried alongside each instruction
//   CNT_W    width of illegal_count
//
// Ports
//   clk            in   1      clock, rising edge
//   rst            in   1      asynchronous reset, active-high
//   flush          in   1      synchronous kill of every in-flight entry
//   in_valid       in   1      upstream instruction valid
//   in_ready       out  1      stage 0 can accept this cycle
//   in_instr       in   32     instruction word
//   in_tag         in   TAG_W  sideband tag (ROB/PC index)
//   out_valid      out  1      decoded entry available
//   out_ready      in   1      downstream accepts
//   out_class      out  14     one-hot class: [0]lui [1]auipc [2]jal [3]jalr
//                              [4]branch [5]load [6]store [7]op-imm [8]op
//                              [9]fence [10]system [11]amo [12]op-imm-32
//                              [13]op-32
//   out_illegal    out  1      entry is illegal (out_class is zero then)
//   out_instr      out  32     instruction word, unchanged
//   out_tag        out  TAG_W  tag, unchanged
//   illegal_count  out  CNT_W  illegal entries delivered, saturating
// ---------------------------------------------------------------------------
module opcode_decode_pipe #(
  parameter int STAGES  = 2,
  parameter int EN_AMO  = 0,
  parameter int EN_RV64 = 0,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [13:0]      out_class,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_count
);

  // One pipeline entry: {class[13:0], illegal, instr[31:0], tag}
  localparam int ENT_W = 14 + 1 + 32 + TAG_W;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Opcode classifier. Returns {class[13:0], illegal}. Only the major opcode
  // is inspected; funct3/funct7 are deliberately ignored. A class whose
  // enable parameter is off decodes as illegal.
  function automatic logic [14:0] decode_op(input logic [31:0] instr);
    logic [13:0] cls;
    cls = 14'b0;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'b0110111: cls[0]  = 1'b1;            // lui
        7'b0010111: cls[1]  = 1'b1;            // auipc
        7'b1101111: cls[2]  = 1'b1;            // jal
        7'b1100111: cls[3]  = 1'b1;            // jalr
        7'b1100011: cls[4]  = 1'b1;            // branch
        7'b0000011: cls[5]  = 1'b1;            // load
        7'b0100011: cls[6]  = 1'b1;            // store
        7'b0010011: cls[7]  = 1'b1;            // op-imm
        7'b0110011: cls[8]  = 1'b1;            // op
        7'b0001111: cls[9]  = 1'b1;            // fence
        7'b1110011: cls[10] = 1'b1;            // system
        7'b0101111: cls[11] = (EN_AMO != 0);   // amo
        7'b0011011: cls[12] = (EN_RV64 != 0);  // op-imm-32
        7'b0111011: cls[13] = (EN_RV64 != 0);  // op-32
        default:    cls     = 14'b0;
      endcase
    end else begin
      // Compressed / reserved low bits are never a legal 32-bit encoding
      cls = 14'b0;
    end
    return {cls, (cls == 14'b0)};
  endfunction

  logic [14:0]      dec_s;
  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] ready_s;
  logic [STAGES-1:0] prev_v_s;
  logic [ENT_W-1:0] data_r      [STAGES];
  logic [ENT_W-1:0] prev_data_s [STAGES];
  logic [CNT_W-1:0] cnt_r;
  logic             deliver_ill_s;

  assign dec_s = decode_op(in_instr);

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    // Unrolled form of ready[g] = ~v[g] | ready[g+1]: stage g may load when
    // any stage from g to the output holds a bubble or the output drains.
    assign ready_s[g] = out_ready | ~(&v_r[STAGES-1:g]);

    if (g == 0) begin : g_head
      assign prev_v_s[g]    = in_valid;
      assign prev_data_s[g] = {dec_s, in_instr, in_tag};
    end else begin : g_body
      assign prev_v_s[g]    = v_r[g-1];
      assign prev_data_s[g] = data_r[g-1];
    end

    // Stage data register; loads whenever the stage advances, stale data
    // behind a cleared valid bit is harmless.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_r[g] <= {ENT_W{1'b0}};
      end else if (ready_s[g]) begin
        data_r[g] <= prev_data_s[g];
      end else begin
        data_r[g] <= data_r[g];
      end
    end
  end

  // Stage valid bits: flush kills everything, including a beat offered this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= {STAGES{1'b0}};
    end else if (flush) begin
      v_r <= {STAGES{1'b0}};
    end else begin
      v_r <= (v_r & ~ready_s) | (prev_v_s & ready_s);
    end
  end

  // An illegal entry is counted on the edge it is handed downstream
  assign deliver_ill_s = out_valid & out_ready & out_illegal;

  // Saturating illegal-entry counter; flush does not touch it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (deliver_ill_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready      = ready_s[0];
  assign out_valid     = v_r[STAGES-1];
  assign out_class     = data_r[STAGES-1][ENT_W-1 -: 14];
  assign out_illegal   = data_r[STAGES-1][32 + TAG_W];
  assign out_instr     = data_r[STAGES-1][TAG_W +: 32];
  assign out_tag       = data_r[STAGES-1][TAG_W-1:0];
  assign illegal_count = cnt_r;

endmodule
